// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-resolution definitions: B-type funct3 codes (including the
// two reserved encodings) and the condition decoder used by the result stage.
package branch_resolve_unit_pkg;

    // B-type funct3 codes
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_ILL_010 = 3'b010;
    localparam logic [2:0] F3_ILL_011 = 3'b011;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    // Fall-through distance for a 32-bit branch instruction
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic taken;
        logic illegal;
    } br_dec_t;

    // Map funct3 plus the registered compare flags onto a branch decision.
    // Reserved encodings report illegal and are never taken.
    function automatic br_dec_t decode_branch(
        input logic [2:0] funct3,
        input logic       eq,
        input logic       lt,
        input logic       ltu
    );
        br_dec_t d;
        d.taken   = 1'b0;
        d.illegal = 1'b0;
        case (funct3)
            F3_BEQ:  d.taken = eq;
            F3_BNE:  d.taken = !eq;
            F3_BLT:  d.taken = lt;
            F3_BGE:  d.taken = !lt;
            F3_BLTU: d.taken = ltu;
            F3_BGEU: d.taken = !ltu;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/branch_cond_cmp.sv
// Purely combinational operand comparator: equality, signed and unsigned
// less-than for an XLEN-bit datapath.
module branch_cond_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution unit. S1 registers compare flags, target and
// fall-through PC; S2 registers the decoded outcome. The pair of stages acts
// as a 2-entry buffer with valid/ready on both sides, a flush that kills
// in-flight work, and saturating branch/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_misaligned,
    output logic             out_illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage valids
    logic s1_valid_reg;
    logic s2_valid_reg;

    // S1 payload
    logic            s1_eq_reg;
    logic            s1_lt_reg;
    logic            s1_ltu_reg;
    logic            s1_pred_reg;
    logic [2:0]      s1_funct3_reg;
    logic [XLEN-1:0] s1_target_reg;
    logic [XLEN-1:0] s1_fall_reg;

    // S2 payload (drives the result outputs directly)
    logic            s2_taken_reg;
    logic            s2_mispredict_reg;
    logic            s2_misaligned_reg;
    logic            s2_illegal_reg;
    logic [XLEN-1:0] s2_target_reg;
    logic [XLEN-1:0] s2_redirect_reg;

    // Statistics
    logic [CNT_W-1:0] br_count_reg;
    logic [CNT_W-1:0] mispred_count_reg;

    // Comparator outputs for the incoming bundle
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_ltu;

    // Handshake terms
    logic s2_advance;
    logic accept;
    logic s2_load;
    logic out_fire;

    // S2 next-state values
    br_dec_t         s2_dec;
    logic            s2_taken_next;
    logic            s2_mispredict_next;
    logic            s2_misaligned_next;
    logic [XLEN-1:0] s2_redirect_next;

    branch_cond_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .a   (in_rs1),
        .b   (in_rs2),
        .eq  (cmp_eq),
        .lt  (cmp_lt),
        .ltu (cmp_ltu)
    );

    assign s2_advance = !s2_valid_reg || out_ready;
    assign in_ready   = !flush && (!s1_valid_reg || s2_advance);
    assign out_valid  = s2_valid_reg && !flush;
    assign accept     = in_valid && in_ready;
    assign s2_load    = s2_advance && s1_valid_reg && !flush;
    assign out_fire   = out_valid && out_ready;

    // Decode the S1 contents into the values S2 will capture
    always_comb begin
        s2_dec             = decode_branch(s1_funct3_reg, s1_eq_reg, s1_lt_reg, s1_ltu_reg);
        s2_taken_next      = s2_dec.taken;
        s2_redirect_next   = s2_dec.taken ? s1_target_reg : s1_fall_reg;
        s2_mispredict_next = !s2_dec.illegal && (s2_dec.taken != s1_pred_reg);
        s2_misaligned_next = s2_dec.taken && s1_target_reg[1];
    end

    // Stage occupancy: flush empties both stages, S2 refills from S1 on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
            end else if (s2_advance) begin
                s1_valid_reg <= 1'b0;
            end
            if (s2_advance) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    // S1 payload capture on accept; held otherwise so a stalled entry stays put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_eq_reg     <= 1'b0;
            s1_lt_reg     <= 1'b0;
            s1_ltu_reg    <= 1'b0;
            s1_pred_reg   <= 1'b0;
            s1_funct3_reg <= 3'b000;
            s1_target_reg <= '0;
            s1_fall_reg   <= '0;
        end else if (accept) begin
            s1_eq_reg     <= cmp_eq;
            s1_lt_reg     <= cmp_lt;
            s1_ltu_reg    <= cmp_ltu;
            s1_pred_reg   <= in_pred_taken;
            s1_funct3_reg <= in_funct3;
            s1_target_reg <= in_pc + in_imm;
            s1_fall_reg   <= in_pc + XLEN'(PC_STEP);
        end
    end

    // S2 result capture when S1 holds a live entry and S2 can take it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_taken_reg      <= 1'b0;
            s2_mispredict_reg <= 1'b0;
            s2_misaligned_reg <= 1'b0;
            s2_illegal_reg    <= 1'b0;
            s2_target_reg     <= '0;
            s2_redirect_reg   <= '0;
        end else if (s2_load) begin
            s2_taken_reg      <= s2_taken_next;
            s2_mispredict_reg <= s2_mispredict_next;
            s2_misaligned_reg <= s2_misaligned_next;
            s2_illegal_reg    <= s2_dec.illegal;
            s2_target_reg     <= s1_target_reg;
            s2_redirect_reg   <= s2_redirect_next;
        end
    end

    // Saturating statistics, bumped only on a completed output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else if (out_fire) begin
            if (!s2_illegal_reg && (br_count_reg != CNT_MAX)) begin
                br_count_reg <= br_count_reg + 1'b1;
            end
            if (s2_mispredict_reg && (mispred_count_reg != CNT_MAX)) begin
                mispred_count_reg <= mispred_count_reg + 1'b1;
            end
        end
    end

    assign out_taken       = s2_taken_reg;
    assign out_target      = s2_target_reg;
    assign out_redirect_pc = s2_redirect_reg;
    assign out_mispredict  = s2_mispredict_reg;
    assign out_misaligned  = s2_misaligned_reg;
    assign out_illegal     = s2_illegal_reg;
    assign br_count        = br_count_reg;
    assign mispred_count   = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 32-bit instance for condition,
// handshake, back-pressure, flush and reset behaviour, and a 64-bit instance
// with 2-bit counters for PC wrap-around and counter saturation.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit instance
    logic        a_flush, a_in_valid, a_in_ready, a_pred, a_out_valid, a_out_ready;
    logic [31:0] a_rs1, a_rs2, a_pc, a_imm, a_target, a_redirect;
    logic [2:0]  a_funct3;
    logic        a_taken, a_mispred, a_misal, a_illegal;
    logic [31:0] a_br_count, a_mp_count;

    // 64-bit instance with 2-bit counters
    logic        b_flush, b_in_valid, b_in_ready, b_pred, b_out_valid, b_out_ready;
    logic [63:0] b_rs1, b_rs2, b_pc, b_imm, b_target, b_redirect;
    logic [2:0]  b_funct3;
    logic        b_taken, b_mispred, b_misal, b_illegal;
    logic [1:0]  b_br_count, b_mp_count;

    int n_assert = 0;
    int n_fail   = 0;

    // back-to-back bookkeeping
    int          k, got, occ;
    logic [31:0] exp_redir [8];
    logic        exp_mp    [8];
    logic        rdy_pat   [4];

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_rs1(a_rs1), .in_rs2(a_rs2), .in_funct3(a_funct3),
        .in_pc(a_pc), .in_imm(a_imm), .in_pred_taken(a_pred),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_taken(a_taken), .out_target(a_target), .out_redirect_pc(a_redirect),
        .out_mispredict(a_mispred), .out_misaligned(a_misal), .out_illegal(a_illegal),
        .br_count(a_br_count), .mispred_count(a_mp_count)
    );

    branch_resolve_unit #(.XLEN(64), .CNT_W(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_rs1(b_rs1), .in_rs2(b_rs2), .in_funct3(b_funct3),
        .in_pc(b_pc), .in_imm(b_imm), .in_pred_taken(b_pred),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_taken(b_taken), .out_target(b_target), .out_redirect_pc(b_redirect),
        .out_mispredict(b_mispred), .out_misaligned(b_misal), .out_illegal(b_illegal),
        .br_count(b_br_count), .mispred_count(b_mp_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle to the 32-bit unit for a single edge
    task automatic send_a(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        a_funct3 = f3; a_rs1 = rs1; a_rs2 = rs2; a_pc = pc; a_imm = imm; a_pred = pred;
        a_in_valid = 1'b1;
        #1;
        chk("send_a_in_ready", 64'(a_in_ready), 64'd1);
        $display("txn32 f3=%b rs1=%h rs2=%h pc=%h imm=%h pred=%b", f3, rs1, rs2, pc, imm, pred);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] f3, input logic [63:0] rs1, input logic [63:0] rs2,
                          input logic [63:0] pc, input logic [63:0] imm, input logic pred);
        b_funct3 = f3; b_rs1 = rs1; b_rs2 = rs2; b_pc = pc; b_imm = imm; b_pred = pred;
        b_in_valid = 1'b1;
        #1;
        chk("send_b_in_ready", 64'(b_in_ready), 64'd1);
        $display("txn64 f3=%b rs1=%h rs2=%h pc=%h imm=%h pred=%b", f3, rs1, rs2, pc, imm, pred);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_pred = 0; a_out_ready = 1;
        a_rs1 = 0; a_rs2 = 0; a_pc = 0; a_imm = 0; a_funct3 = 0;
        b_flush = 0; b_in_valid = 0; b_pred = 0; b_out_ready = 1;
        b_rs1 = 0; b_rs2 = 0; b_pc = 0; b_imm = 0; b_funct3 = 0;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst_in_ready",  64'(a_in_ready), 64'd1);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_taken",     64'(a_taken), 64'd0);
        chk("rst_target",    64'(a_target), 64'd0);
        chk("rst_redirect",  64'(a_redirect), 64'd0);
        chk("rst_mispred",   64'(a_mispred), 64'd0);
        chk("rst_illegal",   64'(a_illegal), 64'd0);
        chk("rst_br",        64'(a_br_count), 64'd0);
        chk("rst_mp",        64'(a_mp_count), 64'd0);
        chk("rst_b_valid",   64'(b_out_valid), 64'd0);
        chk("rst_b_ready",   64'(b_in_ready), 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---- BLT -1 < 1, predicted not taken ----
        send_a(F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h20, 1'b0);
        chk("blt_lat_s1", 64'(a_out_valid), 64'd0);
        tick();
        chk("blt_valid",    64'(a_out_valid), 64'd1);
        chk("blt_taken",    64'(a_taken), 64'd1);
        chk("blt_target",   64'(a_target), 64'h1020);
        chk("blt_redirect", 64'(a_redirect), 64'h1020);
        chk("blt_mispred",  64'(a_mispred), 64'd1);
        chk("blt_misal",    64'(a_misal), 64'd0);
        chk("blt_mp_pre",   64'(a_mp_count), 64'd0);
        tick();
        chk("blt_mp_post",  64'(a_mp_count), 64'd1);
        chk("blt_br_post",  64'(a_br_count), 64'd1);
        chk("blt_drained",  64'(a_out_valid), 64'd0);

        // ---- BGEU 1 >= 0xFFFFFFFF unsigned: false ----
        send_a(F3_BGEU, 32'h1, 32'hFFFF_FFFF, 32'h2000, 32'h100, 1'b1);
        tick();
        chk("bgeu_taken",    64'(a_taken), 64'd0);
        chk("bgeu_redirect", 64'(a_redirect), 64'h2004);
        chk("bgeu_target",   64'(a_target), 64'h2100);
        chk("bgeu_mispred",  64'(a_mispred), 64'd1);
        // ---- BGE 1 >= -1 signed: true ----
        send_a(F3_BGE, 32'h1, 32'hFFFF_FFFF, 32'h2000, 32'h100, 1'b1);
        tick();
        chk("bge_taken",    64'(a_taken), 64'd1);
        chk("bge_redirect", 64'(a_redirect), 64'h2100);
        chk("bge_mispred",  64'(a_mispred), 64'd0);
        tick();
        chk("bge_br", 64'(a_br_count), 64'd3);
        chk("bge_mp", 64'(a_mp_count), 64'd2);

        // ---- illegal funct3 010 ----
        send_a(F3_ILL_010, 32'h5, 32'h5, 32'h3000, 32'h40, 1'b1);
        tick();
        chk("ill_valid",    64'(a_out_valid), 64'd1);
        chk("ill_flag",     64'(a_illegal), 64'd1);
        chk("ill_taken",    64'(a_taken), 64'd0);
        chk("ill_mispred",  64'(a_mispred), 64'd0);
        chk("ill_misal",    64'(a_misal), 64'd0);
        chk("ill_redirect", 64'(a_redirect), 64'h3004);
        tick();
        chk("ill_br", 64'(a_br_count), 64'd3);
        chk("ill_mp", 64'(a_mp_count), 64'd2);

        // ---- misaligned: taken BNE to 0x1006, then not-taken BEQ to same ----
        send_a(F3_BNE, 32'h1, 32'h2, 32'h1000, 32'h6, 1'b1);
        tick();
        chk("bne_taken",   64'(a_taken), 64'd1);
        chk("bne_misal",   64'(a_misal), 64'd1);
        chk("bne_mispred", 64'(a_mispred), 64'd0);
        send_a(F3_BEQ, 32'h1, 32'h2, 32'h1000, 32'h6, 1'b0);
        tick();
        chk("beqnt_misal",    64'(a_misal), 64'd0);
        chk("beqnt_redirect", 64'(a_redirect), 64'h1004);
        tick();
        chk("mis_br", 64'(a_br_count), 64'd5);

        // ---- asynchronous reset mid-operation ----
        send_a(F3_BEQ, 32'h7, 32'h7, 32'h6000, 32'h8, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_br",    64'(a_br_count), 64'd0);
        chk("arst_mp",    64'(a_mp_count), 64'd0);
        chk("arst_ready", 64'(a_in_ready), 64'd1);
        tick();
        chk("arst_valid", 64'(a_out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_lost",  64'(a_out_valid), 64'd0);

        // ---- 8 back-to-back BEQs, out_ready pattern 1,0,0,1 ----
        for (int i = 0; i < 8; i++) begin
            exp_redir[i] = 32'h4000 + 32'(i * 16) + (((i % 2) == 0) ? 32'h8 : 32'h4);
            exp_mp[i]    = ((i % 2) == 0);
        end
        k = 0; got = 0; occ = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            a_out_ready = rdy_pat[c % 4];
            a_in_valid  = (k < 8);
            a_funct3    = F3_BEQ;
            a_rs1       = 32'(k);
            a_rs2       = ((k % 2) == 0) ? 32'(k) : 32'(k + 1);
            a_pc        = 32'h4000 + 32'(k * 16);
            a_imm       = 32'h8;
            a_pred      = 1'b0;
            #1;
            chk("b2b_in_ready", 64'(a_in_ready), (occ == 2 && !a_out_ready) ? 64'd0 : 64'd1);
            if (a_out_valid && a_out_ready) begin
                if (got < 8) begin
                    chk("b2b_redirect", 64'(a_redirect), 64'(exp_redir[got]));
                    chk("b2b_mispred",  64'(a_mispred), 64'(exp_mp[got]));
                end
                $display("b2b out #%0d redirect=%h mispred=%b", got, a_redirect, a_mispred);
                got++;
                occ--;
            end
            if (a_in_valid && a_in_ready) begin
                k++;
                occ++;
            end
            @(posedge clk);
            #1;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("b2b_delivered", 64'(got), 64'd8);
        tick(); tick();
        chk("b2b_no_dup", 64'(a_out_valid), 64'd0);
        chk("b2b_br",     64'(a_br_count), 64'd8);
        chk("b2b_mp",     64'(a_mp_count), 64'd4);

        // ---- flush with both stages full ----
        a_out_ready = 1'b0;
        send_a(F3_BEQ, 32'h1, 32'h1, 32'h5000, 32'h8, 1'b0);
        send_a(F3_BEQ, 32'h2, 32'h2, 32'h5100, 32'h8, 1'b0);
        chk("fl_full_valid", 64'(a_out_valid), 64'd1);
        chk("fl_full_ready", 64'(a_in_ready), 64'd0);
        a_flush = 1'b1;
        a_out_ready = 1'b1;
        a_funct3 = F3_BEQ; a_rs1 = 32'h3; a_rs2 = 32'h3; a_pc = 32'h5200;
        a_in_valid = 1'b1;
        #1;
        chk("fl_cyc_valid", 64'(a_out_valid), 64'd0);
        chk("fl_cyc_ready", 64'(a_in_ready), 64'd0);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("fl_next_valid", 64'(a_out_valid), 64'd0);
        chk("fl_next_ready", 64'(a_in_ready), 64'd1);
        chk("fl_br",         64'(a_br_count), 64'd8);
        chk("fl_mp",         64'(a_mp_count), 64'd4);
        tick();
        chk("fl_empty",      64'(a_out_valid), 64'd0);

        // ---- 64-bit: wrap-around target and counter saturation ----
        b_funct3 = F3_BEQ; b_rs1 = 64'h5; b_rs2 = 64'h5;
        b_pc = 64'hFFFF_FFFF_FFFF_FFFC; b_imm = 64'h8; b_pred = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            $display("txn64 rep %0d BEQ pc=%h imm=%h", i, b_pc, b_imm);
            tick();
            if (b_out_valid) begin
                chk("w64_target",   b_target, 64'h4);
                chk("w64_redirect", b_redirect, 64'h4);
                chk("w64_taken",    64'(b_taken), 64'd1);
                chk("w64_mispred",  64'(b_mispred), 64'd1);
            end
        end
        b_in_valid = 1'b0;
        tick(); tick();
        chk("sat_br",    64'(b_br_count), 64'd3);
        chk("sat_mp",    64'(b_mp_count), 64'd3);
        chk("sat_valid", 64'(b_out_valid), 64'd0);

        send_b(F3_BEQ, 64'h5, 64'h6, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b0);
        tick();
        chk("fall64_taken",    64'(b_taken), 64'd0);
        chk("fall64_redirect", b_redirect, 64'h0);
        chk("fall64_mispred",  64'(b_mispred), 64'd0);
        send_b(F3_BNE, 64'h1, 64'h0, 64'h0, 64'h2, 1'b1);
        tick();
        chk("mis64_misal",    64'(b_misal), 64'd1);
        chk("mis64_redirect", b_redirect, 64'h2);
        tick();
        chk("sat_br_hold", 64'(b_br_count), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
